// File: rtl/spi_slave_responder.sv
// spi_slave_responder -- SPI mode-0 slave that decodes framed register
// transactions in the local CLK domain.
//
// Frame: 8-bit header {rw, addr[6:0]} (rw=1 read) followed by any number of
// DATA_W-bit words, MSB first. Writes produce a one-cycle reg_wen per word.
// Reads issue reg_ren and shift the returned word out on MISO. The address
// auto-increments per word and wraps.
//
// Optional build macro: SPI_HDR_STATUS_EN. When it is defined, sta_in is
// shifted out on MISO during the header. Otherwise MISO is 0 in the header.
//
// Ports:
//   CLK, rst_n             local clock (>= 8x SCK), async active-low reset
//   spi_sck/cs/mosi        SPI inputs (asynchronous to CLK)
//   spi_miso, spi_miso_oe  SPI output and its enable (enable high while CS is low)
//   reg_wen/waddr/wdata    write strobe port
//   reg_ren/raddr, rdata   read port; rdata is valid 1 CLK after reg_ren
//   sta_in                 status byte for the header phase (optional build)
//   frame_done/frame_err   one-cycle end-of-frame pulses
//   word_cnt               words completed in last frame (saturating)
module spi_slave_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              reg_wen,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_ren,
  output logic [ADDR_W-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic [7:0]        sta_in,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       word_cnt
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] WR_DATA = 2'd2;
  localparam logic [1:0] RD_DATA = 2'd3;
  localparam int CW = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;

  // Synchronizers reset to 0: a CS that is already low at reset release
  // is therefore never seen as a fall. An in-progress frame is ignored
  // until CS goes high and falls again.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  logic [1:0]        state;
  logic [CW-1:0]     bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rx, tx;
  logic              rd_cap;

  logic              last_hdr, last_word;
  logic [7:0]        hdr_nxt;
  logic [DATA_W-1:0] rx_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [15:0]       wcnt_inc;
  assign last_hdr  = sck_rise && (bit_cnt == CW'(7));
  assign last_word = sck_rise && (bit_cnt == CW'(DATA_W-1));
  assign rx_nxt    = {rx[DATA_W-2:0], mosi_s};
  assign hdr_nxt   = rx_nxt[7:0];
  assign addr_inc  = addr + ADDR_W'(1);
  assign wcnt_inc  = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

`ifndef SPI_HDR_STATUS_EN
  logic unused_sta;
  assign unused_sta = ^sta_in;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      addr        <= '0;
      rx          <= '0;
      tx          <= '0;
      rd_cap      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      reg_wen     <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      reg_ren     <= 1'b0;
      reg_raddr   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      word_cnt    <= '0;
    end else begin
      reg_wen    <= 1'b0;
      reg_ren    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rd_cap     <= reg_ren;   // rdata lands the cycle after reg_ren

      if (state == IDLE) begin
        if (cs_fall) begin
          state       <= HDR;
          bit_cnt     <= '0;
          word_cnt    <= '0;
          spi_miso_oe <= 1'b1;
`ifdef SPI_HDR_STATUS_EN
          spi_miso    <= sta_in[7];
          tx          <= {sta_in[6:0], {(DATA_W-7){1'b0}}};
`else
          spi_miso    <= 1'b0;
          tx          <= '0;
`endif
        end
      end else if (cs_rise) begin
        // A bit whose rising edge coincides with the CS rise is counted
        // before the frame is judged complete or aborted.
        state       <= IDLE;
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b0;
        bit_cnt     <= '0;
        tx          <= '0;
        if (state == HDR) begin
          if (last_hdr)                         frame_done <= 1'b1;
          else if (bit_cnt != '0 || sck_rise)   frame_err  <= 1'b1;
        end else if (last_word) begin
          if (state == WR_DATA) begin
            reg_wen   <= 1'b1;
            reg_waddr <= addr;
            reg_wdata <= rx_nxt;
          end
          addr       <= addr_inc;
          word_cnt   <= wcnt_inc;
          frame_done <= 1'b1;
        end else if (bit_cnt == '0 && !sck_rise) begin
          frame_done <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
        end
      end else begin
        case (state)
          HDR: begin
            if (sck_fall) begin
              spi_miso <= tx[DATA_W-1];
              tx       <= {tx[DATA_W-2:0], 1'b0};
            end
            if (sck_rise) begin
              rx <= rx_nxt;
              if (last_hdr) begin
                addr    <= ADDR_W'(hdr_nxt[6:0]);
                bit_cnt <= '0;
                if (hdr_nxt[7]) begin
                  state     <= RD_DATA;
                  reg_ren   <= 1'b1;
                  reg_raddr <= ADDR_W'(hdr_nxt[6:0]);
                end else begin
                  state     <= WR_DATA;
                end
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          WR_DATA: begin
            if (sck_rise) begin
              rx <= rx_nxt;
              if (last_word) begin
                reg_wen   <= 1'b1;
                reg_waddr <= addr;
                reg_wdata <= rx_nxt;
                addr      <= addr_inc;
                word_cnt  <= wcnt_inc;
                bit_cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          RD_DATA: begin
            if (rd_cap) begin
              tx <= reg_rdata;
            end else if (sck_fall) begin
              spi_miso <= tx[DATA_W-1];
              tx       <= {tx[DATA_W-2:0], 1'b0};
            end
            if (sck_rise) begin
              if (last_word) begin
                // Prefetch the next word; it is captured well before the
                // falling edge that shifts out its MSB.
                addr      <= addr_inc;
                word_cnt  <= wcnt_inc;
                bit_cnt   <= '0;
                reg_ren   <= 1'b1;
                reg_raddr <= addr_inc;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_responder.sv
`timescale 1ns/1ps
module tb_spi_slave_responder;
  localparam int K_WEN = 1, K_REN = 2, K_DONE = 3, K_ERR = 4;
`ifdef SPI_HDR_STATUS_EN
  localparam logic [7:0] EXP_HDR = 8'hC3;
`else
  localparam logic [7:0] EXP_HDR = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n, spi_sck, spi_cs, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        reg_wen, reg_ren, frame_done, frame_err;
  logic [6:0]  reg_waddr, reg_raddr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = '0;
  logic [7:0]  sta_in;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  spi_slave_responder dut (
    .CLK(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_ren(reg_ren), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .sta_in(sta_in), .frame_done(frame_done), .frame_err(frame_err),
    .word_cnt(word_cnt)
  );

  // Register memory: read data appears one CLK after reg_ren.
  logic [31:0] mem [0:127];
  always @(posedge clk) if (reg_ren) reg_rdata <= mem[reg_raddr];

  typedef struct { int k; logic [6:0] a; logic [31:0] d; } ev_t;
  ev_t         exp_q[$];
  logic [31:0] exp_miso_q[$];
  int          n_chk = 0, n_pass = 0;
  bit          chk_hdr = 0, rd_chk = 0;
  logic [31:0] dw [0:1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic push(input int k, input logic [6:0] a, input logic [31:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic see(input string name, input int k, input logic [6:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected event addr=%h data=%h", name, a, d);
    end else begin
      e = exp_q.pop_front();
      chk(name, {k[7:0], a, d}, {e.k[7:0], e.a, e.d});
    end
  endtask

  // Event monitor: strobes and frame pulses against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wen)    see("wen",  K_WEN,  reg_waddr, reg_wdata);
      if (reg_ren)    see("ren",  K_REN,  reg_raddr, 32'h0);
      if (frame_done) see("done", K_DONE, 7'h0, {16'h0, word_cnt});
      if (frame_err)  see("err",  K_ERR,  7'h0, {16'h0, word_cnt});
    end
  end

  // MISO monitor: samples on SCK rise like the master does.
  initial begin
    int mbit;
    logic [7:0]  hacc;
    logic [31:0] wacc;
    mbit = 0; hacc = '0; wacc = '0;
    forever begin
      @(posedge spi_sck or negedge spi_cs);
      if (!spi_sck) mbit = 0;
      else if (!spi_cs) begin
        if (mbit < 8) begin
          hacc = {hacc[6:0], spi_miso};
          if (mbit == 7 && chk_hdr) chk("miso_hdr", {56'h0, hacc}, {56'h0, EXP_HDR});
        end else if (rd_chk) begin
          wacc = {wacc[30:0], spi_miso};
          if ((mbit - 8) % 32 == 31) begin
            if (exp_miso_q.size() == 0) begin
              n_chk++;
              $display("FAIL miso_word: unexpected word %h", wacc);
            end else chk("miso_word", {32'h0, wacc}, {32'h0, exp_miso_q.pop_front()});
          end
        end
        mbit++;
      end
    end
  end

  function automatic logic bitval(input logic [7:0] h, input int i);
    int j;
    if (i < 8) return h[7-i];
    j = i - 8;
    return dw[j/32][31 - j%32];
  endfunction

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe",   {63'h0, spi_miso_oe}, 64'h0);
    chk("rst_mid_miso", {63'h0, spi_miso},    64'h0);
    chk("rst_mid_ren",  {63'h0, reg_ren},     64'h0);
    chk("rst_mid_wcnt", {48'h0, word_cnt},    64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Mode-0 master: half period 5 CLKs. Optional CS rise on the last
  // rising edge, and optional reset before bit rst_at.
  task automatic frame(input logic [7:0] hdr, input int ndata, input bit coincide, input int rst_at);
    int n;
    n = 8 + ndata;
    @(negedge clk) spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) mid_reset();
      spi_mosi = bitval(hdr, i);
      repeat (5) @(negedge clk);
      spi_sck = 1'b1;
      if (coincide && i == n-1) spi_cs = 1'b1;
      repeat (5) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi_cs = 1'b1; spi_mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    rst_n = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; sta_in = 8'hC3;
    repeat (3) @(negedge clk);
    chk("rst_miso",  {63'h0, spi_miso},    64'h0);
    chk("rst_oe",    {63'h0, spi_miso_oe}, 64'h0);
    chk("rst_wen",   {63'h0, reg_wen},     64'h0);
    chk("rst_ren",   {63'h0, reg_ren},     64'h0);
    chk("rst_done",  {63'h0, frame_done},  64'h0);
    chk("rst_err",   {63'h0, frame_err},   64'h0);
    chk("rst_wcnt",  {48'h0, word_cnt},    64'h0);
    chk("rst_addr",  {50'h0, reg_waddr, reg_raddr}, 64'h0);
    chk("rst_wdata", {32'h0, reg_wdata},   64'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write frame: two words at 5 and 6.
    chk_hdr = 1; rd_chk = 0;
    dw[0] = 32'hDEADBEEF; dw[1] = 32'h12345678;
    push(K_WEN, 7'h05, 32'hDEADBEEF);
    push(K_WEN, 7'h06, 32'h12345678);
    push(K_DONE, 7'h0, 32'd2);
    frame(8'h05, 64, 0, -1);
    chk("wr_wcnt_held", {48'h0, word_cnt}, 64'd2);

    // Read frame at 7F, wrapping to 00; the last prefetch targets 01.
    mem[7'h7F] = 32'hA5A5A5A5; mem[7'h00] = 32'h0F0F0F0F; mem[7'h01] = 32'h11111111;
    dw[0] = 32'h0; dw[1] = 32'h0;
    rd_chk = 1;
    exp_miso_q.push_back(32'hA5A5A5A5);
    exp_miso_q.push_back(32'h0F0F0F0F);
    push(K_REN, 7'h7F, 32'h0);
    push(K_REN, 7'h00, 32'h0);
    push(K_REN, 7'h01, 32'h0);
    push(K_DONE, 7'h0, 32'd2);
    frame(8'hFF, 64, 0, -1);
    rd_chk = 0;

    // Abort after 13 data bits of a write.
    dw[0] = 32'hFFFFFFFF;
    push(K_ERR, 7'h0, 32'd0);
    frame(8'h10, 13, 0, -1);

    // Empty frame: neither done nor err.
    @(negedge clk) spi_cs = 1'b0;
    repeat (10) @(negedge clk);
    spi_cs = 1'b1;
    repeat (12) @(negedge clk);

    // CS rises together with the 32nd rising edge.
    dw[0] = 32'hCAFEF00D;
    push(K_WEN, 7'h20, 32'hCAFEF00D);
    push(K_DONE, 7'h0, 32'd1);
    frame(8'h20, 32, 1, -1);
    chk("coinc_wcnt", {48'h0, word_cnt}, 64'd1);

    // Reset in the middle of a read; the rest of that frame is ignored.
    mem[7'h03] = 32'h33333333;
    dw[0] = 32'h0;
    push(K_REN, 7'h03, 32'h0);
    frame(8'h83, 20, 0, 18);
    chk("post_rst_wcnt", {48'h0, word_cnt}, 64'd0);

    // A full frame after reset behaves normally.
    dw[0] = 32'h01020304;
    push(K_WEN, 7'h44, 32'h01020304);
    push(K_DONE, 7'h0, 32'd1);
    frame(8'h44, 32, 0, -1);
    chk("post_rst_frame_wcnt", {48'h0, word_cnt}, 64'd1);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("miso_drained", 64'(exp_miso_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Chip-side SPI responder: the far end of the SPI master driven by `fpga_top`.
- Oversamples SCK/CS/MOSI in the local CLK domain and decodes framed register transactions.
- Issues write strobes, or fetches read data for MISO, against a generic register/weight-memory port.
- Used as the chip model in FPGA loopback benches and as the RTL front end of the chip's SPI slave.

Parameters:
- DATA_W, 32: data word width in bits; must match the host FIFO word.
- ADDR_W, 7: register address width; header carries exactly 7 address bits.
- SYNC_STAGES, 2: synchronizer flops on spi_sck, spi_cs and spi_mosi; legal values 2..3.

Ports:
- CLK  in  1  local clock; must be >= 8x the SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data; 0 when not driving.
- spi_miso_oe  out  1  MISO output enable; 1 only while CS is low.
- reg_wen  out  1  one-cycle write strobe.
- reg_waddr  out  ADDR_W  write address.
- reg_wdata  out  DATA_W  write data.
- reg_ren  out  1  one-cycle read request.
- reg_raddr  out  ADDR_W  read address.
- reg_rdata  in  DATA_W  read data, valid exactly 1 CLK after reg_ren.
- sta_in  in  8  status byte (used only with the optional feature).
- frame_done  out  1  one-cycle pulse on a clean CS rise.
- frame_err  out  1  one-cycle pulse on an aborted frame.
- word_cnt  out  16  data words completed in the last frame; held until the next CS fall.

Behaviour:
- Reset: every output is 0; FSM in IDLE; all shift registers, bit counter and address are 0.
- Input synchronization:
  - SCK, CS and MOSI pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronized SCK samples.
  - Rising edge samples MOSI; falling edge updates MISO.
- Frame format:
  - First 8 bits are the header {rw, addr[6:0]}; rw=1 is a read.
  - The header is followed by any number of DATA_W-bit words.
- FSM states: IDLE, HDR, WR_DATA, RD_DATA.
- IDLE -> HDR on synchronized CS fall:
  - clear bit counter and word_cnt;
  - set spi_miso_oe=1 and spi_miso=0.
- HDR: at the 8th rising edge, latch addr and go to WR_DATA (rw=0) or RD_DATA (rw=1).
  - On the RD_DATA entry, reg_ren pulses in the same cycle with reg_raddr=addr.
- WR_DATA:
  - Shift MOSI in on each rising edge.
  - At the DATA_W-th bit, in the cycle after the edge detect: reg_wen=1, reg_waddr=addr, reg_wdata=assembled word.
  - Then addr+1 (wraps 2^ADDR_W-1 -> 0), word_cnt+1, bit counter cleared.
- RD_DATA:
  - Capture reg_rdata into the TX shift register 1 CLK after reg_ren.
  - On each falling edge: spi_miso <= TX MSB; shift TX left.
  - At the DATA_W-th rising edge: addr+1 (same wrap), word_cnt+1, reg_ren for the new addr.
  - This prefetch lands before the next falling edge given the CLK >= 8x SCK rule.
  - MOSI is ignored.
- word_cnt saturates at 16'hFFFF.
- Any state -> IDLE on synchronized CS rise; spi_miso_oe=0, spi_miso=0 in the same cycle.
  - Bit counter == 0 and state != HDR-with-partial-bits: frame_done pulse.
  - Otherwise (partial header or partial word): frame_err pulse; partial data discarded; no reg_wen issued.
  - CS high with no bits received is neither done nor error.
- Simultaneous events: a CS rise in the same CLK as the last-bit rising-edge detect counts the word complete (strobe issued, then frame_done).
- reg_wen and reg_ren are never asserted in the same cycle.
- Reset mid-frame aborts immediately. After reset the block waits for a fresh CS fall; a frame already in progress is ignored until CS goes high.

Optional Feature:
- Macro: SPI_HDR_STATUS_EN.
- Defined: at the CS fall, sta_in is loaded into the TX register. MISO returns sta_in MSB-first during the 8 header bits, changing on falling edges; first bit valid at the CS fall.
- Undefined: sta_in is unused; MISO is 0 during the header.

Test Plan:
- Write frame: header 8'h05, words 32'hDEADBEEF and 32'h12345678 -> reg_wen at addr 5 then 6 with those data; frame_done=1; word_cnt=2.
- Read frame: header 8'h80|7'h7F, 2 words, memory[7F]=32'hA5A5A5A5 and memory[00]=32'h0F0F0F0F -> MISO bits match both words; reg_raddr 7F then 00 (wrap).
- Abort: CS rises after 13 data bits of a write -> no reg_wen for that word; frame_err=1; frame_done=0.
- CS rise coincident with the 32nd rising edge -> reg_wen issued; frame_done=1; word_cnt=1.
- Async reset asserted mid-read -> all outputs 0 within the reset; after the next full frame, behaviour is correct.
- With SPI_HDR_STATUS_EN and sta_in=8'hC3 -> header-phase MISO = 1,1,0,0,0,0,1,1.
